blake2_msg_sched: RTL and testbench

- Message scheduler that sequences the blake2 core over a complete hash job.
- Accepts a host byte stream with a valid/ready handshake and slices it into BB-byte blocks.
- Zero-pads the final block and tracks the total byte count (ll).
- Drives the core's byte-load, block_first/block_last, ll/kk/nn inputs, and holds off the next block until the core finishes each compression.

---
 rtl/blake2_msg_sched_if.sv | 40 ++++
 rtl/blake2_msg_sched.sv | 132 +++++++++++++
 tb/tb_blake2_msg_sched.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/blake2_msg_sched_if.sv
// Host byte stream and blake2 core sequencing signals for the message scheduler.
// The scheduler takes the slave view; the host/core environment takes the master view.
interface blake2_msg_sched_if #(
  parameter int BB   = 128,
  parameter int LL_W = 64
);
  localparam int BB_CLOG2 = $clog2(BB);

  // host byte stream
  logic                msg_v_i;
  logic [7:0]          msg_data_i;
  logic                msg_last_i;
  logic                msg_ready_o;

  // core load side
  logic                core_data_v_o;
  logic [7:0]          core_data_o;
  logic [BB_CLOG2-1:0] core_data_idx_o;
  logic                core_block_first_o;
  logic                core_block_last_o;
  logic [LL_W-1:0]     core_ll_o;
  logic [7:0]          core_kk_o;
  logic [7:0]          core_nn_o;

  // core completion pulses
  logic                core_f_done_i;
  logic                core_hash_v_i;

  modport slave (
    input  msg_v_i, msg_data_i, msg_last_i, core_f_done_i, core_hash_v_i,
    output msg_ready_o, core_data_v_o, core_data_o, core_data_idx_o,
           core_block_first_o, core_block_last_o, core_ll_o, core_kk_o, core_nn_o
  );

  modport master (
    output msg_v_i, msg_data_i, msg_last_i, core_f_done_i, core_hash_v_i,
    input  msg_ready_o, core_data_v_o, core_data_o, core_data_idx_o,
           core_block_first_o, core_block_last_o, core_ll_o, core_kk_o, core_nn_o
  );
endinterface

// File: rtl/blake2_msg_sched.sv
// Blake2 message scheduler: slices a host byte stream into BB-byte blocks,
// zero-pads the final block, tracks the total byte count and paces the core
// one compression at a time. BB must be a power of two.
module blake2_msg_sched #(
  parameter int BB       = 128,
  parameter int BB_CLOG2 = $clog2(BB),
  parameter int LL_W     = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             start_empty_i,
  input  logic [7:0]       cfg_kk_i,
  input  logic [7:0]       cfg_nn_i,
  output logic             busy_o,
  output logic             done_o,
  blake2_msg_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MSG,
    S_PAD,
    S_WAIT_F,
    S_WAIT_H
  } state_t;

  localparam logic [BB_CLOG2-1:0] IDX_LAST = BB_CLOG2'(BB - 1);

  state_t              state;
  logic [BB_CLOG2-1:0] idx;
  logic                first;
  logic                idx_end;

  assign idx_end = (idx == IDX_LAST);

  // NOTE: msg_ready_o is a pure decode of the registered state, so the host
  // sees it settle right after each edge and no combinational path runs from
  // msg_v_i back to msg_ready_o.
  assign bus.msg_ready_o = (state == S_MSG);

  // Job sequencer: state, block index, byte counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: non-blocking assignments throughout; every register here is
      // sequential state and must update together at the edge.
      state                  <= S_IDLE;
      idx                    <= '0;
      first                  <= 1'b0;
      busy_o                 <= 1'b0;
      done_o                 <= 1'b0;
      bus.core_data_v_o      <= 1'b0;
      bus.core_data_o        <= '0;
      bus.core_data_idx_o    <= '0;
      bus.core_block_first_o <= 1'b0;
      bus.core_block_last_o  <= 1'b0;
      bus.core_ll_o          <= '0;
      bus.core_kk_o          <= '0;
      bus.core_nn_o          <= '0;
    end else begin
      bus.core_data_v_o <= 1'b0;
      done_o            <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start_i) begin
            bus.core_kk_o <= cfg_kk_i;
            bus.core_nn_o <= cfg_nn_i;
            bus.core_ll_o <= '0;
            first         <= 1'b1;
            idx           <= '0;
            busy_o        <= 1'b1;
            state         <= start_empty_i ? S_PAD : S_MSG;
          end
        end

        S_MSG: begin
          if (bus.msg_v_i) begin
            bus.core_data_v_o      <= 1'b1;
            bus.core_data_o        <= bus.msg_data_i;
            bus.core_data_idx_o    <= idx;
            bus.core_block_first_o <= first;
            bus.core_block_last_o  <= bus.msg_last_i;
            bus.core_ll_o          <= bus.core_ll_o + LL_W'(1);
            idx                    <= idx + BB_CLOG2'(1);
            if (idx_end && bus.msg_last_i) begin
              state <= S_WAIT_H;
            end else if (idx_end) begin
              state <= S_WAIT_F;
            end else if (bus.msg_last_i) begin
              state <= S_PAD;
            end
          end
        end

        S_PAD: begin
          bus.core_data_v_o      <= 1'b1;
          bus.core_data_o        <= 8'h00;
          bus.core_data_idx_o    <= idx;
          bus.core_block_first_o <= first;
          bus.core_block_last_o  <= 1'b1;
          idx                    <= idx + BB_CLOG2'(1);
          if (idx_end) begin
            state <= S_WAIT_H;
          end
        end

        S_WAIT_F: begin
          if (bus.core_f_done_i) begin
            first <= 1'b0;
            idx   <= '0;
            state <= S_MSG;
          end
        end

        S_WAIT_H: begin
          if (bus.core_hash_v_i) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end
        end

        default: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blake2_msg_sched.sv
// Self-checking bench for blake2_msg_sched: a scoreboard of expected core
// strobes (byte, index, first/last flags and arrival cycle) is filled as
// stimulus is driven and drained by a monitor on the falling edge.
module tb_blake2_msg_sched;

  localparam int BB   = 128;
  localparam int LL_W = 64;

  typedef struct {
    logic [7:0] data;
    logic [6:0] idx;
    logic       first;
    logic       last;
    int         cyc;
  } sb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_i = 1'b0;
  logic start_empty_i = 1'b0;
  logic [7:0] cfg_kk_i = '0;
  logic [7:0] cfg_nn_i = '0;
  logic busy_o;
  logic done_o;

  blake2_msg_sched_if #(.BB(BB), .LL_W(LL_W)) bus ();

  blake2_msg_sched #(.BB(BB), .LL_W(LL_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .start_empty_i (start_empty_i),
    .cfg_kk_i      (cfg_kk_i),
    .cfg_nn_i      (cfg_nn_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int  cyc = 0;
  int  tests_run = 0;
  int  tests_failed = 0;
  int  done_cnt = 0;
  int  ready_seen = 0;
  bit  watch_ready = 1'b0;
  sb_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input int i, input logic f, input logic l, input int c);
    sb_t e;
    e.data  = d;
    e.idx   = 7'(i);
    e.first = f;
    e.last  = l;
    e.cyc   = c;
    sb.push_back(e);
  endtask

  // Strobe monitor, sampled half a cycle away from the active edge.
  always @(negedge clk) begin
    if (bus.core_data_v_o) begin
      if (sb.size() == 0) begin
        check("sb_extra_strobe", 64'd1, 64'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("strobe", {bus.core_data_o, bus.core_data_idx_o, bus.core_block_first_o, bus.core_block_last_o},
              {e.data, e.idx, e.first, e.last});
        check("strobe_cyc", 64'(cyc), 64'(e.cyc));
      end
    end
    if (done_o) done_cnt++;
    if (watch_ready && bus.msg_ready_o) ready_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] kk, input logic [7:0] nn, input logic empty, output int s);
    cfg_kk_i      = kk;
    cfg_nn_i      = nn;
    start_i       = 1'b1;
    start_empty_i = empty;
    tick();
    s             = cyc;
    start_i       = 1'b0;
    start_empty_i = 1'b0;
    cfg_kk_i      = 8'hEE;
    cfg_nn_i      = 8'hEE;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (sb.size() != 0 && w < 400) begin
      tick();
      w++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  // Drive a message; mark_last=0 leaves the job open (used before a reset).
  task automatic send_msg(input logic [7:0] bytes[$], input bit gap, input bit mark_last);
    int  idx = 0;
    bit  first = 1'b1;
    int  n = bytes.size();
    for (int i = 0; i < n; i++) begin
      int  w = 0;
      int  a;
      logic lst;
      lst = mark_last && (i == n - 1);
      bus.msg_v_i    = 1'b1;
      bus.msg_data_i = bytes[i];
      bus.msg_last_i = lst;
      while (!bus.msg_ready_o && w < 1000) begin
        tick();
        w++;
      end
      if (w >= 1000) begin
        check("ready_timeout", 64'd0, 64'd1);
        bus.msg_v_i = 1'b0;
        return;
      end
      tick();
      a = cyc;
      push(bytes[i], idx, first, lst, a);
      bus.msg_v_i    = 1'b0;
      bus.msg_last_i = 1'b0;
      if (gap) tick();
      if (lst && idx != BB - 1) begin
        for (int j = idx + 1; j < BB; j++) push(8'h00, j, first, 1'b1, a + (j - idx));
      end
      if (idx == BB - 1 && !lst) begin
        wait_drain();
        repeat (3) tick();
        check("ready_wait_f", 64'(bus.msg_ready_o), 64'd0);
        check("busy_wait_f", 64'(busy_o), 64'd1);
        bus.core_f_done_i = 1'b1;
        tick();
        bus.core_f_done_i = 1'b0;
        first = 1'b0;
        idx   = 0;
      end else begin
        idx++;
      end
    end
  endtask

  task automatic finish_job(input logic [63:0] ll, input logic [7:0] kk, input logic [7:0] nn);
    int d0;
    wait_drain();
    check("ll", bus.core_ll_o, ll);
    check("kk", 64'(bus.core_kk_o), 64'(kk));
    check("nn", 64'(bus.core_nn_o), 64'(nn));
    // A stray compression-done pulse in the hash wait must be ignored.
    bus.core_f_done_i = 1'b1;
    tick();
    bus.core_f_done_i = 1'b0;
    tick();
    check("ready_wait_h", 64'(bus.msg_ready_o), 64'd0);
    check("busy_wait_h", 64'(busy_o), 64'd1);
    d0 = done_cnt;
    bus.core_hash_v_i = 1'b1;
    tick();
    bus.core_hash_v_i = 1'b0;
    check("done_pulse", 64'(done_o), 64'd1);
    check("busy_after", 64'(busy_o), 64'd0);
    tick();
    check("done_clear", 64'(done_o), 64'd0);
    check("done_count", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_v"},     64'(bus.core_data_v_o), 64'd0);
    check({tag, "_data"},  64'(bus.core_data_o), 64'd0);
    check({tag, "_idx"},   64'(bus.core_data_idx_o), 64'd0);
    check({tag, "_first"}, 64'(bus.core_block_first_o), 64'd0);
    check({tag, "_last"},  64'(bus.core_block_last_o), 64'd0);
    check({tag, "_ll"},    bus.core_ll_o, 64'd0);
    check({tag, "_kknn"},  64'({bus.core_kk_o, bus.core_nn_o}), 64'd0);
    check({tag, "_busy"},  64'(busy_o), 64'd0);
    check({tag, "_done"},  64'(done_o), 64'd0);
    check({tag, "_ready"}, 64'(bus.msg_ready_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] msg[$];
    int s;
    int d0;

    bus.msg_v_i       = 1'b0;
    bus.msg_data_i    = '0;
    bus.msg_last_i    = 1'b0;
    bus.core_f_done_i = 1'b0;
    bus.core_hash_v_i = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check_all_zero("reset");

    // "abc", unkeyed, 64-byte digest
    msg = '{8'h61, 8'h62, 8'h63};
    start_job(8'd0, 8'd64, 1'b0, s);
    send_msg(msg, 1'b0, 1'b1);
    finish_job(64'd3, 8'd0, 8'd64);

    // empty message: one all-zero block, host never sees ready
    ready_seen  = 0;
    watch_ready = 1'b1;
    start_job(8'd0, 8'd32, 1'b1, s);
    for (int j = 0; j < BB; j++) push(8'h00, j, 1'b1, 1'b1, s + 1 + j);
    finish_job(64'd0, 8'd0, 8'd32);
    watch_ready = 1'b0;
    check("empty_ready", 64'(ready_seen), 64'd0);

    // exactly one full block, last on byte 127: no padding
    msg = {};
    for (int i = 0; i < BB; i++) msg.push_back(8'($urandom_range(1, 255)));
    start_job(8'd0, 8'd64, 1'b0, s);
    send_msg(msg, 1'b0, 1'b1);
    finish_job(64'd128, 8'd0, 8'd64);

    // 129 bytes, keyed config: two blocks with a compression wait between
    msg = {};
    for (int i = 0; i < BB + 1; i++) msg.push_back(8'($urandom_range(0, 255)));
    start_job(8'd16, 8'd48, 1'b0, s);
    send_msg(msg, 1'b0, 1'b1);
    finish_job(64'd129, 8'd16, 8'd48);

    // valid toggling every cycle on 5 bytes
    msg = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    start_job(8'd0, 8'd20, 1'b0, s);
    send_msg(msg, 1'b1, 1'b1);
    finish_job(64'd5, 8'd0, 8'd20);

    // reset in the middle of a block (next byte would be idx 40)
    msg = {};
    for (int i = 0; i < 40; i++) msg.push_back(8'(i + 1));
    d0 = done_cnt;
    start_job(8'd7, 8'd9, 1'b0, s);
    send_msg(msg, 1'b0, 1'b0);
    check("pre_rst_ll", bus.core_ll_o, 64'd40);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("midrst");
    check("midrst_sb", 64'(sb.size()), 64'd0);
    repeat (3) tick();
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);

    // fresh job after the abort
    msg = '{8'hA5, 8'h5A};
    start_job(8'd0, 8'd64, 1'b0, s);
    send_msg(msg, 1'b0, 1'b1);
    finish_job(64'd2, 8'd0, 8'd64);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
